// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with valid/ready handshakes on both sides
//   clk      : sole clock, rising edge
//   reset    : synchronous, active-high; clears pointers and count, not storage
//   wr_valid : producer offers wr_data
//   wr_data  : word to enqueue
//   wr_ready : FIFO has space (count < DEPTH), low during reset
//   rd_valid : rd_data holds the oldest word (count > 0), low during reset
//   rd_data  : oldest stored word
//   rd_ready : consumer takes rd_data
//   count    : number of stored words, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_valid,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       wr_ready,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_fire, rd_fire;
   // flags depend only on registered count and reset, never on the handshake inputs
   assign wr_ready = !reset && count != FULL;
   assign rd_valid = !reset && count != '0;
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_fire  = rd_ready && rd_valid;
   assign rd_data  = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_fire) - CW'(rd_fire);
      end
   end
   // storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based model
module tb_sync_fifo;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr_valid = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             wr_ready;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ready = 1'b0;
   logic [$clog2(DEPTH):0] count;
   int tests = 0;
   int fails = 0;
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] got[$];
   int max_cnt;
   bit record = 0;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_ready(rd_ready), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a FIFO is a queue; space and data availability come straight from its size
   always @(posedge clk) begin
      logic wf, rf;
      if (reset) q.delete();
      else begin
         wf = wr_valid && q.size() < DEPTH;
         rf = rd_ready && q.size() > 0;
         if (rf) void'(q.pop_front());
         if (wf) q.push_back(wr_data);
      end
   end

   // single compare process, mid-cycle
   always @(negedge clk) begin
      chk("wr_ready", 32'(wr_ready), 32'(!reset && q.size() < DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(!reset && q.size() > 0));
      chk("count", 32'(count), 32'(q.size()));
      if (!reset && q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
      if (record) begin
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (rd_valid && rd_ready) got.push_back(rd_data);
      end
   end

   task automatic drv(input logic r, input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
      @(posedge clk);
      #1;
      reset = r;
      wr_valid = wv;
      wr_data = wd;
      rd_ready = rr;
   endtask

   initial begin
      drv(1, 0, 0, 0);
      drv(1, 0, 0, 0);
      // reset then idle
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("post_reset_wr_ready", 32'(wr_ready), 1);
      chk("post_reset_rd_valid", 32'(rd_valid), 0);
      chk("post_reset_count", 32'(count), 0);
      drv(0, 0, 0, 0);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("idle_count_stable", 32'(count), 0);
      // single word
      drv(0, 1, 16'hA5A5, 0);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("single_rd_valid", 32'(rd_valid), 1);
      chk("single_rd_data", 32'(rd_data), 32'hA5A5);
      chk("single_count", 32'(count), 1);
      drv(0, 0, 0, 1);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("single_drained_count", 32'(count), 0);
      chk("single_drained_rd_valid", 32'(rd_valid), 0);
      // fill to full
      for (int i = 1; i <= 4; i++) drv(0, 1, 16'(i), 0);
      drv(0, 1, 16'h0005, 0);
      @(negedge clk);
      chk("full_count", 32'(count), 4);
      chk("full_wr_ready", 32'(wr_ready), 0);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("full_ignored_count", 32'(count), 4);
      // full plus simultaneous read/write
      drv(0, 1, 16'h0005, 1);
      @(negedge clk);
      chk("full_rw_rd_data", 32'(rd_data), 32'h0001);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("full_rw_count", 32'(count), 3);
      for (int i = 2; i <= 4; i++) begin
         drv(0, 0, 0, 1);
         @(negedge clk);
         chk("full_rw_order", 32'(rd_data), 32'(i));
      end
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("full_rw_empty", 32'(count), 0);
      // wrap and streaming
      max_cnt = 0;
      got.delete();
      record = 1;
      for (int i = 0; i < 20; i++) drv(0, 1, 16'(16'h0100 + i), 1);
      drv(0, 0, 0, 1);
      drv(0, 0, 0, 1);
      @(posedge clk);
      #1;
      record = 0;
      chk("stream_words", 32'(got.size()), 20);
      for (int i = 0; i < 20 && i < got.size(); i++) chk("stream_order", 32'(got[i]), 32'(16'h0100 + i));
      chk("stream_max_count_le1", 32'(max_cnt <= 1), 1);
      // reset mid-fill
      drv(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drv(0, 1, 16'(16'h0300 + i), 0);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("midfill_count", 32'(count), 3);
      drv(1, 1, 16'h1111, 1);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("midfill_reset_count", 32'(count), 0);
      chk("midfill_reset_rd_valid", 32'(rd_valid), 0);
      drv(0, 1, 16'hBEEF, 0);
      drv(0, 0, 0, 0);
      @(negedge clk);
      chk("midfill_first_word", 32'(rd_data), 32'hBEEF);
      chk("midfill_first_valid", 32'(rd_valid), 1);
      // randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++)
         drv($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45);
      drv(0, 0, 0, 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
